// File: rtl/z_branch.sv
// Conditional-branch unit: evaluates JMP/JMPZ/JPNZ against the flag register,
// fetches a two-byte target or requests a skip. Optional macro: Z_BRANCH_TIMEOUT_EN.
module z_branch #(
  parameter int AW  = 16,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    zin,
  input  logic          start,
  input  logic [1:0]    cond,
  input  logic [7:0]    bus_in,
  input  logic          bus_vld,
  output logic          op_req,
  output logic          busy,
  output logic          pc_load,
  output logic          pc_skip,
  output logic [AW-1:0] pc_target,
  output logic          taken,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EVAL     = 3'd1,
    FETCH_LO = 3'd2,
    FETCH_HI = 3'd3,
    LOAD     = 3'd4,
    SKIP     = 3'd5
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] cond_q;
  logic       zero_q;
  logic       take_c;
  logic       fetching;
  logic       tmo_hit;

  assign dbg_state = state;
  assign fetching  = (state == FETCH_LO) || (state == FETCH_HI);

  // Decision uses only the values captured with start; zin may move afterwards.
  always_comb begin
    take_c = 1'b0;
    case (cond_q)
      2'b00:   take_c = 1'b1;
      2'b01:   take_c = zero_q;
      2'b10:   take_c = !zero_q;
      default: take_c = 1'b0;
    endcase
  end

`ifdef Z_BRANCH_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt;
  assign tmo_hit = fetching && !bus_vld && (cnt == CW'(TMO - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TMO == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (start) nxt = EVAL;
      EVAL:     nxt = take_c ? FETCH_LO : SKIP;
      FETCH_LO: if (bus_vld) nxt = FETCH_HI;
                else if (tmo_hit) nxt = SKIP;
      FETCH_HI: if (bus_vld) nxt = LOAD;
                else if (tmo_hit) nxt = SKIP;
      LOAD:     nxt = IDLE;
      SKIP:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Pulse outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cond_q    <= 2'b00;
      zero_q    <= 1'b0;
      op_req    <= 1'b0;
      busy      <= 1'b0;
      pc_load   <= 1'b0;
      pc_skip   <= 1'b0;
      done      <= 1'b0;
      taken     <= 1'b0;
      err       <= 1'b0;
      pc_target <= '0;
`ifdef Z_BRANCH_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state   <= nxt;
      op_req  <= (nxt == FETCH_LO) || (nxt == FETCH_HI);
      busy    <= (nxt != IDLE);
      pc_load <= (nxt == LOAD);
      pc_skip <= (nxt == SKIP);
      done    <= (nxt == LOAD) || (nxt == SKIP);

      if (state == IDLE && start) begin
        cond_q <= cond;
        zero_q <= (zin == 8'h00);
        err    <= 1'b0;
        taken  <= 1'b0;
      end

      if (state == EVAL) begin
        taken <= take_c;
        if (cond_q == 2'b11) err <= 1'b1;
      end

      if (state == FETCH_LO && bus_vld) pc_target[7:0] <= bus_in;
      if (state == FETCH_HI && bus_vld) pc_target[AW-1:8] <= (AW-8)'(bus_in);

      if (tmo_hit) begin
        err   <= 1'b1;
        taken <= 1'b0;
      end

`ifdef Z_BRANCH_TIMEOUT_EN
      if (nxt != state)
        cnt <= '0;
      else if (fetching && !bus_vld)
        cnt <= cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_z_branch.sv
// Directed bench for z_branch: completion records are queued at start and
// compared when done pulses; cycle-exact checks are made along the way.
module tb_z_branch;
  localparam int AW = 16;
  localparam int W  = AW + 4;

  logic          clk;
  logic          rst;
  logic [7:0]    zin;
  logic          start;
  logic [1:0]    cond;
  logic [7:0]    bus_in;
  logic          bus_vld;
  logic          op_req;
  logic          busy;
  logic          pc_load;
  logic          pc_skip;
  logic [AW-1:0] pc_target;
  logic          taken;
  logic          done;
  logic          err;
  logic [2:0]    dbg_state;

  logic [W-1:0]  exp_q[$];
  int            tests;
  int            fails;
  int            cyc_n;
  int            done_cnt;
  int            done_base;
  logic          armed;

  z_branch #(.AW(AW), .TMO(15)) dut (
    .clk(clk), .rst(rst), .zin(zin), .start(start), .cond(cond),
    .bus_in(bus_in), .bus_vld(bus_vld), .op_req(op_req), .busy(busy),
    .pc_load(pc_load), .pc_skip(pc_skip), .pc_target(pc_target),
    .taken(taken), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic begin_start(input logic [1:0] c, input logic [7:0] z);
    step();
    cyc_n = 0;
    cond  = c;
    zin   = z;
    start = 1'b1;
  endtask

  task automatic push_exp(input logic ld, input logic sk, input logic tk,
                          input logic er, input logic [AW-1:0] tgt);
    exp_q.push_back({ld, sk, tk, er, tgt});
  endtask

  task automatic wait_done(input int budget, input int exp_cyc, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < budget);
    check(tag, cyc_n, exp_cyc);
  endtask

  // scoreboard: every done must match the oldest queued record
  always @(negedge clk) begin
    if (armed) begin
      check("load_skip_excl", {31'd0, pc_load & pc_skip}, 32'd0);
      if (done === 1'b1) begin
        done_cnt++;
        check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0)
          check("done_record", {pc_load, pc_skip, taken, err, pc_target}, exp_q.pop_front());
      end
    end
  end

  initial begin
    tests = 0; fails = 0; cyc_n = 0; done_cnt = 0; armed = 1'b0;
    rst = 1'b0; start = 1'b1; cond = 2'b00; zin = 8'h00; bus_in = 8'h00; bus_vld = 1'b0;

    // reset held two cycles with start asserted
    step(); step();
    check("rst_outs", {op_req, busy, pc_load, pc_skip, taken, done, err}, 0);
    check("rst_target", pc_target, 0);
    step();
    rst = 1'b1; start = 1'b0; armed = 1'b1;

    // JMPZ taken, bytes on consecutive cycles
    begin_start(2'b01, 8'h00);
    push_exp(1'b1, 1'b0, 1'b1, 1'b0, 16'h1234);
    step(); start = 1'b0;
    check("jmpz_c1_busy", busy, 1);
    check("jmpz_c1_opreq", op_req, 0);
    step();
    check("jmpz_c2_opreq", op_req, 1);
    bus_in = 8'h34; bus_vld = 1'b1;
    step();
    check("jmpz_c3_opreq", op_req, 1);
    bus_in = 8'h12;
    step(); bus_vld = 1'b0;
    check("jmpz_c4_load_done", {pc_load, done}, 2'b11);
    check("jmpz_target", pc_target, 16'h1234);
    check("jmpz_taken", taken, 1);
    step();
    check("jmpz_c5_idle", busy, 0);

    // JPNZ not taken
    begin_start(2'b10, 8'h00);
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    step(); start = 1'b0;
    check("jpnz_c1_opreq", op_req, 0);
    step();
    check("jpnz_c2_skip_done_opreq_taken", {pc_skip, done, op_req, taken}, 4'b1100);

    // JMP with stalls, zin toggling, stray starts and stray bus_vld
    begin_start(2'b00, 8'h05);
    push_exp(1'b1, 1'b0, 1'b1, 1'b0, 16'hCDAB);
    done_base = done_cnt;
    step();
    start = 1'b1; zin = 8'h00; bus_in = 8'hEE; bus_vld = 1'b1;
    step();
    start = 1'b0; bus_in = 8'hAB; bus_vld = 1'b1; zin = 8'h05;
    step();
    bus_vld = 1'b0; zin = 8'h00;
    step(); start = 1'b1;
    step(); start = 1'b0;
    step(); bus_in = 8'hCD; bus_vld = 1'b1;
    wait_done(20, 7, "stall_load_cycle");
    bus_vld = 1'b0;
    check("stall_pc_load", pc_load, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_done_ignored", busy, 0);
    check("stall_single_done", done_cnt - done_base, 1);

    // reserved condition sets sticky err
    begin_start(2'b11, 8'h00);
    push_exp(1'b0, 1'b1, 1'b0, 1'b1, 16'hCDAB);
    step(); start = 1'b0;
    step();
    check("rsv_skip_err", {pc_skip, err}, 2'b11);
    step();
    check("rsv_err_sticky", {busy, err}, 2'b01);

    // next accepted start clears err
    begin_start(2'b01, 8'h01);
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, 16'hCDAB);
    step(); start = 1'b0;
    check("err_cleared", err, 0);
    step();
    check("jmpz_nt_skip", pc_skip, 1);

    // reset in FETCH_HI abandons the transaction
    begin_start(2'b00, 8'h00);
    step(); start = 1'b0;
    step(); bus_in = 8'h11; bus_vld = 1'b1;
    step();
    check("midrst_in_fetch_hi", {op_req, busy}, 2'b11);
    bus_vld = 1'b0; rst = 1'b0;
    step();
    check("midrst_outs", {busy, pc_load, done, op_req, pc_skip}, 0);
    check("midrst_target", pc_target, 0);
    rst = 1'b1;
    repeat (3) step();

`ifdef Z_BRANCH_TIMEOUT_EN
    begin_start(2'b00, 8'h00);
    push_exp(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    step(); start = 1'b0;
    wait_done(40, 17, "tmo_latency");
    check("tmo_taken_err", {taken, err, pc_skip}, 3'b011);
`else
    begin_start(2'b00, 8'h00);
    push_exp(1'b1, 1'b0, 1'b1, 1'b0, 16'h5678);
    step(); start = 1'b0;
    repeat (100) step();
    check("wait_opreq", op_req, 1);
    check("wait_busy", busy, 1);
    check("wait_no_done", done, 0);
    bus_in = 8'h78; bus_vld = 1'b1;
    step(); bus_in = 8'h56;
    wait_done(10, 103, "late_fetch_load");
    bus_vld = 1'b0;
`endif

    step(); step();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
